// File: rtl/fir_xifu_issuer.sv
// Encodes FIR commands into custom instructions, drives X-interface issue/commit, returns results.
// Cmd at N -> issue valid at N+1, commit one cycle after issue handshake; cmd stalls at MAX_OUTSTANDING, results stall on full rsp register.
module fir_xifu_issuer #(
  parameter int X_ID_WIDTH      = 4,
  parameter int MAX_OUTSTANDING = 4,
  localparam int OW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [4:0]            cmd_rs1_i,
  input  logic [4:0]            cmd_rs2_i,
  input  logic [4:0]            cmd_rd_i,
  input  logic [11:0]           cmd_imm_i,
  input  logic [31:0]           cmd_rs1_val_i,
  input  logic [31:0]           cmd_rs2_val_i,
  output logic                  x_issue_valid_o,
  input  logic                  x_issue_ready_i,
  output logic [31:0]           x_issue_instr_o,
  output logic [X_ID_WIDTH-1:0] x_issue_id_o,
  output logic [31:0]           x_issue_rs1_o,
  output logic [31:0]           x_issue_rs2_o,
  input  logic                  x_issue_accept_i,
  input  logic                  x_issue_writeback_i,
  output logic                  x_commit_valid_o,
  output logic [X_ID_WIDTH-1:0] x_commit_id_o,
  output logic                  x_commit_kill_o,
  input  logic                  x_result_valid_i,
  output logic                  x_result_ready_o,
  input  logic [X_ID_WIDTH-1:0] x_result_id_i,
  input  logic [4:0]            x_result_rd_i,
  input  logic [31:0]           x_result_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [4:0]            rsp_rd_o,
  output logic [31:0]           rsp_data_o,
  output logic [X_ID_WIDTH-1:0] rsp_id_o,
  output logic                  rej_o,
  output logic                  err_o,
  output logic [OW-1:0]         outstanding_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  localparam logic [6:0] OPCODE = 7'b1011011;

  logic [1:0]            state_q, state_d;
  logic [X_ID_WIDTH-1:0] id_cnt_q;
  logic [OW-1:0]         out_q, out_d;
  logic                  run_q, rdy_q, accept_q;
  logic [31:0]           enc_instr;
  logic                  cmd_hs, cmd_bad, issue_hs, res_hs, inc, dec;

  assign cmd_hs   = cmd_valid_i & cmd_ready_o;
  assign cmd_bad  = cmd_op_i == 2'b11;
  assign issue_hs = x_issue_valid_o & x_issue_ready_i;
  assign res_hs   = x_result_valid_i & x_result_ready_o;
  assign inc      = issue_hs & x_issue_accept_i & x_issue_writeback_i;
  assign dec      = res_hs & (out_q != '0);

  always_comb begin
    case (cmd_op_i)
      2'b00:   enc_instr = {cmd_imm_i, cmd_rs1_i, 3'b000, cmd_rd_i, OPCODE};
      2'b01:   enc_instr = {cmd_imm_i[11:5], cmd_rs2_i, cmd_rs1_i, 3'b001, cmd_imm_i[4:0], OPCODE};
      default: enc_instr = {7'b0, cmd_rs2_i, cmd_rs1_i, 3'b010, cmd_rd_i, OPCODE};
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_hs && !cmd_bad) state_d = ISSUE;
      ISSUE:   if (issue_hs) state_d = COMMIT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_d = out_q;
    if (inc && !dec) out_d = out_q + OW'(1);
    else if (!inc && dec) out_d = out_q - OW'(1);
  end

  // Ready is registered from next-cycle state/count so it is low throughout reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      id_cnt_q <= '0;
      out_q    <= '0;
      run_q    <= 1'b0;
      rdy_q    <= 1'b0;
      accept_q <= 1'b0;
      rej_o    <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      run_q   <= 1'b1;
      rdy_q   <= (state_d == IDLE) && (out_d < OW'(MAX_OUTSTANDING));
      rej_o   <= (cmd_hs && cmd_bad) || (issue_hs && !x_issue_accept_i);
      if (issue_hs) begin
        id_cnt_q <= id_cnt_q + 1'b1;
        accept_q <= x_issue_accept_i;
      end
      if (res_hs && out_q == '0) err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_issue_instr_o <= '0;
      x_issue_id_o    <= '0;
      x_issue_rs1_o   <= '0;
      x_issue_rs2_o   <= '0;
    end else if (cmd_hs && !cmd_bad) begin
      x_issue_instr_o <= enc_instr;
      x_issue_id_o    <= id_cnt_q;
      x_issue_rs1_o   <= cmd_rs1_val_i;
      x_issue_rs2_o   <= cmd_rs2_val_i;
    end
  end

  // Results with nothing outstanding are swallowed; only err_o records them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o <= 1'b0;
      rsp_rd_o    <= '0;
      rsp_data_o  <= '0;
      rsp_id_o    <= '0;
    end else if (dec) begin
      rsp_valid_o <= 1'b1;
      rsp_rd_o    <= x_result_rd_i;
      rsp_data_o  <= x_result_data_i;
      rsp_id_o    <= x_result_id_i;
    end else if (rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

  assign cmd_ready_o      = rdy_q;
  assign x_result_ready_o = run_q & (~rsp_valid_o | rsp_ready_i);
  assign x_issue_valid_o  = state_q == ISSUE;
  assign x_commit_valid_o = state_q == COMMIT;
  assign x_commit_id_o    = x_issue_id_o;
  assign x_commit_kill_o  = (state_q == COMMIT) & ~accept_q;
  assign outstanding_o    = out_q;

endmodule

// File: tb/tb_fir_xifu_issuer.sv
// Scoreboard bench for fir_xifu_issuer: directed cases plus random traffic against a queue-based model.
module tb_fir_xifu_issuer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0, cmd_ready_o;
  logic [1:0]  cmd_op_i = '0;
  logic [4:0]  cmd_rs1_i = '0, cmd_rs2_i = '0, cmd_rd_i = '0;
  logic [11:0] cmd_imm_i = '0;
  logic [31:0] cmd_rs1_val_i = '0, cmd_rs2_val_i = '0;
  logic        x_issue_valid_o, x_issue_ready_i = 1'b0;
  logic [31:0] x_issue_instr_o, x_issue_rs1_o, x_issue_rs2_o;
  logic [3:0]  x_issue_id_o, x_commit_id_o, x_result_id_i = '0, rsp_id_o;
  logic        x_issue_accept_i = 1'b0, x_issue_writeback_i = 1'b0;
  logic        x_commit_valid_o, x_commit_kill_o;
  logic        x_result_valid_i = 1'b0, x_result_ready_o;
  logic [4:0]  x_result_rd_i = '0, rsp_rd_o;
  logic [31:0] x_result_data_i = '0, rsp_data_o;
  logic        rsp_valid_o, rsp_ready_i = 1'b0;
  logic        rej_o, err_o;
  logic [2:0]  outstanding_o;

  fir_xifu_issuer #(.X_ID_WIDTH(4), .MAX_OUTSTANDING(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_rs1_i(cmd_rs1_i), .cmd_rs2_i(cmd_rs2_i), .cmd_rd_i(cmd_rd_i), .cmd_imm_i(cmd_imm_i),
    .cmd_rs1_val_i(cmd_rs1_val_i), .cmd_rs2_val_i(cmd_rs2_val_i),
    .x_issue_valid_o(x_issue_valid_o), .x_issue_ready_i(x_issue_ready_i),
    .x_issue_instr_o(x_issue_instr_o), .x_issue_id_o(x_issue_id_o),
    .x_issue_rs1_o(x_issue_rs1_o), .x_issue_rs2_o(x_issue_rs2_o),
    .x_issue_accept_i(x_issue_accept_i), .x_issue_writeback_i(x_issue_writeback_i),
    .x_commit_valid_o(x_commit_valid_o), .x_commit_id_o(x_commit_id_o), .x_commit_kill_o(x_commit_kill_o),
    .x_result_valid_i(x_result_valid_i), .x_result_ready_o(x_result_ready_o),
    .x_result_id_i(x_result_id_i), .x_result_rd_i(x_result_rd_i), .x_result_data_i(x_result_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rd_o(rsp_rd_o),
    .rsp_data_o(rsp_data_o), .rsp_id_o(rsp_id_o),
    .rej_o(rej_o), .err_o(err_o), .outstanding_o(outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] instr; logic [3:0] id; logic [31:0] a; logic [31:0] b; } iss_t;
  typedef struct { logic [3:0] id; logic kill; } com_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; logic [3:0] id; } rsp_t;

  iss_t exp_iss[$];
  com_t exp_com[$];
  rsp_t exp_rsp[$];
  int   exp_rej = 0;
  int   checks = 0, errors = 0;

  // Reference model state: next id, accepted-writeback ids in flight, sticky error.
  int   m_id = 0, m_out = 0;
  bit   m_err = 0;
  int   m_ids[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input int unsigned op, rs1, rs2, rd, imm);
    logic [31:0] w;
    case (op)
      0:       w = (imm << 20) + (rs1 << 15) + (rd << 7);
      1:       w = ((imm / 32) << 25) + (rs2 << 20) + (rs1 << 15) + (1 << 12) + ((imm % 32) << 7);
      default: w = (rs2 << 20) + (rs1 << 15) + (2 << 12) + (rd << 7);
    endcase
    return w + 32'h5B;
  endfunction

  // Monitor: pops expectations whenever the DUT presents an output.
  iss_t mi, prev;
  com_t mc;
  rsp_t mr;
  bit   held = 0;
  always @(negedge clk_i) begin
    if (!rst_ni) held = 0;
    else begin
      if (x_issue_valid_o) begin
        if (exp_iss.size() == 0) check("unexpected_issue_valid", 1, 0);
        else if (held) begin
          check("issue_instr_stable", x_issue_instr_o, prev.instr);
          check("issue_id_stable", {28'd0, x_issue_id_o}, {28'd0, prev.id});
          check("issue_rs1_stable", x_issue_rs1_o, prev.a);
        end
        if (x_issue_ready_i && exp_iss.size() != 0) begin
          mi = exp_iss.pop_front();
          check("issue_instr", x_issue_instr_o, mi.instr);
          check("issue_id", {28'd0, x_issue_id_o}, {28'd0, mi.id});
          check("issue_rs1", x_issue_rs1_o, mi.a);
          check("issue_rs2", x_issue_rs2_o, mi.b);
        end
      end
      held = x_issue_valid_o && !x_issue_ready_i;
      prev = '{x_issue_instr_o, x_issue_id_o, x_issue_rs1_o, x_issue_rs2_o};
      if (x_commit_valid_o) begin
        if (exp_com.size() == 0) check("unexpected_commit", 1, 0);
        else begin
          mc = exp_com.pop_front();
          check("commit_id", {28'd0, x_commit_id_o}, {28'd0, mc.id});
          check("commit_kill", {31'd0, x_commit_kill_o}, {31'd0, mc.kill});
        end
      end
      if (rsp_valid_o && rsp_ready_i) begin
        if (exp_rsp.size() == 0) check("unexpected_rsp", 1, 0);
        else begin
          mr = exp_rsp.pop_front();
          check("rsp_rd", {27'd0, rsp_rd_o}, {27'd0, mr.rd});
          check("rsp_data", rsp_data_o, mr.data);
          check("rsp_id", {28'd0, rsp_id_o}, {28'd0, mr.id});
        end
      end
      if (rej_o) begin
        if (exp_rej == 0) check("unexpected_rej", 1, 0);
        else exp_rej--;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_i);
      #1 rsp_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_cmd(input int op, rs1, rs2, rd, imm, input bit acc, wb, input int hold);
    int n = 0;
    int iid;
    logic [31:0] v1 = $urandom, v2 = $urandom;
    cmd_valid_i = 1; cmd_op_i = op[1:0]; cmd_rs1_i = rs1[4:0]; cmd_rs2_i = rs2[4:0];
    cmd_rd_i = rd[4:0]; cmd_imm_i = imm[11:0]; cmd_rs1_val_i = v1; cmd_rs2_val_i = v2;
    @(negedge clk_i);
    while (!cmd_ready_o && n < 100) begin @(negedge clk_i); n++; end
    if (n >= 100) begin check("cmd_ready_timeout", 0, 1); cmd_valid_i = 0; return; end
    @(posedge clk_i); #1 cmd_valid_i = 0;
    if (op == 3) begin exp_rej++; return; end
    iid = m_id;
    exp_iss.push_back('{enc(op, rs1, rs2, rd, imm), iid[3:0], v1, v2});
    exp_com.push_back('{iid[3:0], !acc});
    m_id = (m_id + 1) % 16;
    for (int i = 0; i < hold; i++) begin @(posedge clk_i); #1; end
    x_issue_ready_i = 1; x_issue_accept_i = acc; x_issue_writeback_i = wb;
    n = 0;
    @(negedge clk_i);
    while (!x_issue_valid_o && n < 20) begin @(negedge clk_i); n++; end
    if (n >= 20) check("issue_valid_timeout", 0, 1);
    @(posedge clk_i); #1;
    x_issue_ready_i = 0; x_issue_accept_i = 0; x_issue_writeback_i = 0;
    if (!acc) exp_rej++;
    if (acc && wb) begin m_out++; m_ids.push_back(iid); end
    check("outstanding_after_issue", {29'd0, outstanding_o}, m_out);
  endtask

  task automatic send_result(input int id, input int rd, input logic [31:0] data);
    int n = 0;
    x_result_valid_i = 1; x_result_id_i = id[3:0]; x_result_rd_i = rd[4:0]; x_result_data_i = data;
    @(negedge clk_i);
    while (!x_result_ready_o && n < 50) begin @(negedge clk_i); n++; end
    if (n >= 50) begin check("result_ready_timeout", 0, 1); x_result_valid_i = 0; return; end
    @(posedge clk_i); #1 x_result_valid_i = 0;
    if (m_out == 0) m_err = 1;
    else begin m_out--; exp_rsp.push_back('{rd[4:0], data, id[3:0]}); end
    check("outstanding_after_result", {29'd0, outstanding_o}, m_out);
    check("err_after_result", {31'd0, err_o}, {31'd0, m_err});
  endtask

  task automatic result_for(input int id, input logic [31:0] data);
    foreach (m_ids[i]) if (m_ids[i] == id) begin m_ids.delete(i); break; end
    send_result(id, $urandom_range(0, 31), data);
  endtask

  task automatic drain();
    int n = 0;
    while (m_ids.size() > 0) send_result(m_ids.pop_front(), $urandom_range(0, 31), $urandom);
    while (exp_rsp.size() > 0 && n < 100) begin @(posedge clk_i); n++; end
    check("rsp_drained", exp_rsp.size(), 0);
  endtask

  initial begin
    int idx, id;
    #3;
    check("reset_issue_valid", {31'd0, x_issue_valid_o}, 0);
    check("reset_commit_valid", {31'd0, x_commit_valid_o}, 0);
    check("reset_rsp_valid", {31'd0, rsp_valid_o}, 0);
    check("reset_cmd_ready", {31'd0, cmd_ready_o}, 0);
    check("reset_result_ready", {31'd0, x_result_ready_o}, 0);
    check("reset_rej_err", {30'd0, rej_o, err_o}, 0);
    check("reset_outstanding", {29'd0, outstanding_o}, 0);
    check("reset_instr", x_issue_instr_o, 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1;
    repeat (2) @(posedge clk_i);
    #1;

    send_cmd(0, 10, 0, 5, 'h004, 1, 1, 0);
    check("lw_encoding_literal", enc(0, 10, 0, 5, 4), 32'h004502DB);
    result_for(0, $urandom);
    send_cmd(1, 10, 6, 0, 'h008, 1, 0, 0);
    send_cmd(2, 11, 12, 13, 0, 1, 1, 5);
    for (int i = 0; i < 3; i++) send_cmd(0, $urandom_range(0, 31), 0, $urandom_range(0, 31), $urandom_range(0, 4095), 1, 1, 0);
    repeat (2) @(negedge clk_i);
    check("cmd_ready_full", {31'd0, cmd_ready_o}, 0);
    check("outstanding_full", {29'd0, outstanding_o}, 4);
    @(posedge clk_i); #1;
    result_for(2, 32'hDEADBEEF);
    check("cmd_ready_after_result", {31'd0, cmd_ready_o}, 1);
    result_for(5, $urandom);
    result_for(3, $urandom);
    result_for(4, $urandom);

    send_cmd(2, 1, 2, 3, 0, 0, 1, 1);
    send_cmd(3, 1, 2, 3, 0, 1, 1, 0);
    drain();
    send_result(9, 1, 32'h12345678);
    repeat (3) @(negedge clk_i);
    check("err_sticky", {31'd0, err_o}, 1);
    check("err_no_rsp", {31'd0, rsp_valid_o}, 0);
    @(posedge clk_i); #1;

    for (int i = 0; i < 60; i++) begin
      if (m_out > 0 && ($urandom_range(0, 2) == 0 || m_out == 4)) begin
        idx = $urandom_range(0, m_ids.size() - 1);
        id = m_ids[idx];
        m_ids.delete(idx);
        send_result(id, $urandom_range(0, 31), $urandom);
      end else begin
        send_cmd($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 4095),
                 $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3));
      end
    end
    drain();
    repeat (3) @(posedge clk_i);
    check("iss_queue_empty", exp_iss.size(), 0);
    check("com_queue_empty", exp_com.size(), 0);
    check("rej_all_seen", exp_rej, 0);

    // Reset while an issue request is pending.
    #1;
    cmd_valid_i = 1; cmd_op_i = 2'b00;
    @(negedge clk_i);
    while (!cmd_ready_o) @(negedge clk_i);
    @(posedge clk_i); #1 cmd_valid_i = 0;
    exp_iss.push_back('{32'h0, 4'h0, 32'h0, 32'h0});
    @(negedge clk_i);
    check("issue_valid_before_reset", {31'd0, x_issue_valid_o}, 1);
    #2 rst_ni = 0;
    #1;
    check("reset_drops_issue", {31'd0, x_issue_valid_o}, 0);
    check("reset_clears_err", {31'd0, err_o}, 0);
    check("reset_clears_outstanding", {29'd0, outstanding_o}, 0);
    exp_iss.delete(); exp_com.delete(); exp_rsp.delete(); exp_rej = 0;
    m_id = 0; m_out = 0; m_err = 0; m_ids.delete();
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
    repeat (2) @(posedge clk_i); #1;
    send_cmd(0, 3, 0, 4, 'h010, 1, 1, 0);
    drain();
    repeat (3) @(posedge clk_i);
    check("final_iss_queue_empty", exp_iss.size(), 0);
    check("final_com_queue_empty", exp_com.size(), 0);
    check("final_err_clear", {31'd0, err_o}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
